// File: rtl/dcache_ma.sv
// Direct-mapped, write-back, write-allocate data cache for the MA stage.
// Word-level CPU side; 128-bit block transfers to memory over a busywait handshake.
module dcache_ma #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 32 - INDEX_BITS - 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [3:0]   READ,
    input  logic [2:0]   WRITE,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITEDATA,
    output logic [31:0]  READDATA,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);
    localparam int LINES = 1 << INDEX_BITS;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] ALLOCATE  = 2'd2;
    localparam logic [1:0] UPDATE    = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [LINES-1:0]    valid_q, dirty_q;
    logic [TAG_BITS-1:0] tag_q [LINES];
    logic [127:0]        data_q [LINES];
    logic [127:0]        fill_q, fill_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [27:0]         mem_addr_q, mem_addr_d;
    logic [127:0]        mem_wdata_q, mem_wdata_d;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [1:0]            word_off, byte_off;
    logic                  req, rd_req, store_en, hit;
    logic [127:0]          line, merged_line, line_wdata;
    logic [31:0]           cur_word, new_word, load_val;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic                  line_we, fill_line, mark_dirty;

    assign index    = ADDRESS[4+INDEX_BITS-1:4];
    assign tag      = ADDRESS[31:4+INDEX_BITS];
    assign word_off = ADDRESS[3:2];
    assign byte_off = ADDRESS[1:0];

    // A simultaneous read and write enable is serviced as a store.
    assign req      = READ[3] | WRITE[2];
    assign rd_req   = READ[3] & ~WRITE[2];
    assign store_en = WRITE[2] & (WRITE[1:0] != 2'b11);

    assign hit      = valid_q[index] && (tag_q[index] == tag);
    assign line     = data_q[index];
    assign cur_word = line[{word_off, 5'd0} +: 32];

    always_comb begin
        sel_byte = cur_word[{byte_off, 3'd0} +: 8];
        sel_half = cur_word[{ADDRESS[1], 4'd0} +: 16];
        case (READ[2:0])
            3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
            3'b010:  load_val = cur_word;
            3'b100:  load_val = {24'd0, sel_byte};
            3'b101:  load_val = {16'd0, sel_half};
            default: load_val = 32'd0;
        endcase
    end

    always_comb begin
        new_word = cur_word;
        case (WRITE[1:0])
            2'b00:   new_word[{byte_off, 3'd0} +: 8] = WRITEDATA[7:0];
            2'b01:   new_word[{ADDRESS[1], 4'd0} +: 16] = WRITEDATA[15:0];
            2'b10:   new_word = WRITEDATA;
            default: new_word = cur_word;
        endcase
        merged_line = line;
        merged_line[{word_off, 5'd0} +: 32] = new_word;
    end

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        line_we     = 1'b0;
        line_wdata  = merged_line;
        fill_line   = 1'b0;
        mark_dirty  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    if (valid_q[index] && dirty_q[index]) begin
                        state_d     = WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[index], index};
                        mem_wdata_d = line;
                    end else begin
                        state_d    = ALLOCATE;
                        mem_read_d = 1'b1;
                        mem_addr_d = ADDRESS[31:4];
                    end
                end else if (hit && store_en) begin
                    line_we    = 1'b1;
                    mark_dirty = 1'b1;
                end
            end
            WRITEBACK: begin
                // Read request follows the write on the same edge so the port never idles.
                if (!MEM_BUSYWAIT) begin
                    state_d     = ALLOCATE;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = ADDRESS[31:4];
                end
            end
            ALLOCATE: begin
                if (!MEM_BUSYWAIT) begin
                    state_d    = UPDATE;
                    mem_read_d = 1'b0;
                    fill_d     = MEM_READDATA;
                end
            end
            UPDATE: begin
                state_d    = IDLE;
                line_we    = 1'b1;
                line_wdata = fill_q;
                fill_line  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            fill_q      <= 128'd0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 28'd0;
            mem_wdata_q <= 128'd0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (fill_line) begin
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end else if (mark_dirty) begin
                dirty_q[index] <= 1'b1;
            end
        end
    end

    // Line storage carries no reset; the valid bits alone make it meaningful.
    always_ff @(posedge CLK) begin
        if (!RST && line_we) begin
            data_q[index] <= line_wdata;
        end
        if (!RST && fill_line) begin
            tag_q[index] <= tag;
        end
    end

    assign BUSYWAIT      = !RST && ((state_q != IDLE) || (req && !hit));
    assign READDATA      = (!RST && (state_q == IDLE) && rd_req && hit) ? load_val : 32'd0;
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;
endmodule
